// File: rtl/sram_ctrl_pkg.sv
// Shared constants and the read-sequencer state encoding for the weight SRAM controller.
// Contents:
//   ADDR_W, DATA_W, DEPTH  geometry of the 64 x 512b weight SRAM
//   rd_state_e             read sequencer states (IDLE / RUN / DRAIN)
package sram_ctrl_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry {last, data} FIFO that catches SRAM read data one cycle after issue and
// holds it against consumer back-pressure.
// Ports:
//   clk, rst        clock, synchronous active-high flush
//   i_push          store i_push_data / i_push_last this cycle
//   i_pop           drop the head entry this cycle (caller only pops when non-empty)
//   o_head_data     head entry data
//   o_head_last     head entry last tag
//   o_count         number of stored entries (0..2)
module rd_skid_fifo
    import sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_push_last,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_head_last,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        r_last;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // NOTE: the storage is deliberately not reset; an entry is only ever observed after
    // it has been written, and the count/pointers carry the reset state.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_last[r_wr_ptr] <= i_push_last;
        end
    end

    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_last = r_last[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/sram_rw_ctrl.sv
// Shares the 64 x 512b weight SRAM between a write loader and a burst reader feeding the
// systolic array. Writes are accepted every cycle; bursts read consecutive addresses
// (wrapping 63 -> 0) and are delivered through a 2-entry buffer that hides the SRAM's
// 1-cycle read latency and absorbs consumer back-pressure.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data write request (fires on valid & ready)
//   rd_req_valid/rd_req_ready         burst request, accepted only when idle
//   rd_req_addr/rd_req_len            burst start address, beats minus one
//   rd_valid/rd_ready/rd_data/rd_last output beat stream
//   busy                              sequencer not idle
//   sram_csb/sram_wsb                 SRAM chip / write enables, active-low
//   sram_waddr/sram_raddr/sram_wdata  SRAM write address, read address, write data
//   sram_rdata                        SRAM read data, valid the cycle after a read
module sram_rw_ctrl
    import sram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [ADDR_W-1:0] rd_req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [ADDR_W-1:0] sram_raddr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    rd_state_e         r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_rem;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_wr_fire;
    logic              w_rd_req_fire;
    logic              w_rd_valid;
    logic              w_rd_pop;
    logic              w_hazard;
    logic              w_credit;
    logic              w_rd_issue;
    logic              w_drain_done;
    logic [2:0]        w_occupancy;
    logic [2:0]        w_limit;
    logic [1:0]        w_fifo_count;
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_last;

    assign wr_ready      = ~rst;
    assign w_wr_fire     = wr_valid & wr_ready;
    assign rd_req_ready  = ~rst & (r_state == ST_IDLE);
    assign w_rd_req_fire = rd_req_valid & rd_req_ready;

    assign w_rd_valid = ~rst & (w_fifo_count != 2'd0);
    assign w_rd_pop   = w_rd_valid & rd_ready;

    // Buffered plus in-flight beats, less the one leaving this cycle, must stay below the
    // buffer depth so the beat issued now always has a slot when it returns.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_rd_pop};
    assign w_credit    = w_occupancy < w_limit;

    // The SRAM reads the old word when both ports hit one address in the same cycle, so the
    // read waits a cycle and then sees the freshly written data.
    assign w_hazard   = w_wr_fire & (wr_addr == r_cur);
    assign w_rd_issue = ~rst & (r_state == ST_RUN) & w_credit & ~w_hazard;

    // The final beat has left once nothing is in flight and the buffer empties this cycle.
    assign w_drain_done = ~r_inflight & (w_fifo_count == {1'b0, w_rd_pop});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cur           <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_issue & (r_rem == '0);
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req_fire) begin
                        r_cur   <= rd_req_addr;
                        r_rem   <= rd_req_len;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_rd_issue) begin
                        r_cur <= r_cur + 1'b1;
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == '0) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rd_skid_fifo u_rd_skid_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_last (r_inflight_last),
        .i_push_data (sram_rdata),
        .i_pop       (w_rd_pop),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last),
        .o_count     (w_fifo_count)
    );

    assign rd_valid = w_rd_valid;
    assign rd_data  = rst ? '0 : w_head_data;
    assign rd_last  = w_rd_valid & w_head_last;
    assign busy     = ~rst & (r_state != ST_IDLE);

    assign sram_csb   = ~(w_wr_fire | w_rd_issue);
    assign sram_wsb   = ~w_wr_fire;
    assign sram_waddr = rst ? '0 : wr_addr;
    assign sram_raddr = rst ? '0 : r_cur;
    assign sram_wdata = wr_data;

endmodule
